// File: rtl/mem_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_io_responder_pkg
// Purpose : shared constants and IO register decode for mem_io_responder.
//           IO space is selected by cpu_a[17:16] == 2'b11.
//           0x30000 is the byte data port. 0x30004 is stop/counter byte 0.
//           0x30005..0x30007 hold counter snapshot bytes 1..3.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE_ADDR = 18'h30000;
  localparam logic [17:0] IO_STOP_ADDR = 18'h30004;
  localparam logic [1:0]  IO_DECODE    = 2'b11;

  typedef enum logic [2:0] {
    IO_REG_NONE,
    IO_REG_DATA,
    IO_REG_CTRL,
    IO_REG_SNAP1,
    IO_REG_SNAP2,
    IO_REG_SNAP3
  } io_reg_e;

  // Maps an 18-bit IO address to its register; unknown addresses give NONE.
  function automatic io_reg_e io_decode(input logic [17:0] addr);
    io_reg_e sel;
    sel = IO_REG_NONE;
    if (addr == IO_BASE_ADDR)               sel = IO_REG_DATA;
    else if (addr == IO_STOP_ADDR)          sel = IO_REG_CTRL;
    else if (addr == IO_STOP_ADDR + 18'd1)  sel = IO_REG_SNAP1;
    else if (addr == IO_STOP_ADDR + 18'd2)  sel = IO_REG_SNAP2;
    else if (addr == IO_STOP_ADDR + 18'd3)  sel = IO_REG_SNAP3;
    return sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Purpose : circular byte FIFO. It holds DEPTH-1 bytes, because one slot
//           always stays free.
//           A push and a pop in the same cycle always give a net change of
//           zero. This also holds when the FIFO is full. When the FIFO is
//           empty, the pushed byte passes straight to o_rdata and is
//           consumed, so it is never stored.
// Ports   : clk_in, rst_in (async, active-high)
//           i_push/i_wdata : push request and byte
//           i_pop          : pop request (ignored when empty, except bypass)
//           o_rdata        : head byte (or i_wdata while empty)
//           o_full/o_empty/o_count : occupancy status
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       i_push,
  input  logic [7:0]                 i_wdata,
  input  logic                       i_pop,
  output logic [7:0]                 o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_count;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == AW'(DEPTH - 1));
  assign w_bypass  = i_push && i_pop && w_empty;
  assign w_do_pop  = i_pop && !w_empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign w_do_push = i_push && !w_bypass && (!w_full || w_do_pop);

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = w_empty ? i_wdata : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// Purpose : CPU-side responder with a byte RAM and a small IO block. The IO
//           block has an RX byte FIFO, a TX byte FIFO, a stop flag and an
//           optional cycle counter.
//           Optional feature macro: CYCLE_COUNTER_EN. This macro adds the
//           32-bit cycle counter and the snapshot registers.
// Ports   : clk_in, rst_in (async, active-high)
//           cpu_a[31:0], cpu_dout[7:0], cpu_wr : CPU access. Every cycle is a
//             read unless cpu_wr is set.
//           cpu_din[7:0]    : read result, one cycle after the read, held
//           io_buffer_full  : TX occupancy >= TX_DEPTH-2
//           rx_valid/rx_data/rx_ready : host byte stream in
//           tx_valid/tx_data/tx_ready : byte stream out
//           program_stop    : sticky, set by a write to 0x30004
// ---------------------------------------------------------------------------
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop
);

  localparam int RAM_BYTES = 1 << RAM_AW;
  localparam int TX_AW     = $clog2(TX_DEPTH);
  localparam int RX_AW     = $clog2(RX_DEPTH);

  logic [17:0]       w_addr;
  logic              w_is_io;
  io_reg_e           w_io_reg;
  logic              w_unused_addr;
  logic [RAM_AW-1:0] w_ram_addr;

  assign w_addr        = cpu_a[17:0];
  assign w_is_io       = (w_addr[17:16] == IO_DECODE);
  assign w_io_reg      = w_is_io ? io_decode(w_addr) : IO_REG_NONE;
  assign w_unused_addr = ^cpu_a[31:18];
  assign w_ram_addr    = cpu_a[RAM_AW-1:0];

  // ---------------- RAM: write-first across cycles, registered read -------
  logic [7:0] r_ram [RAM_BYTES];
  logic [7:0] r_ram_q;

  always_ff @(posedge clk_in) begin
    if (cpu_wr && !w_is_io) r_ram[w_ram_addr] <= cpu_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                  r_ram_q <= 8'h00;
    else if (!cpu_wr && !w_is_io) r_ram_q <= r_ram[w_ram_addr];
  end

  // ---------------- FIFOs ----------------
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]       w_rx_rdata, w_rx_byte;
  logic [RX_AW-1:0] w_unused_rx_count;
  logic             w_tx_push, w_tx_pop, w_tx_empty, w_unused_tx_full;
  logic [7:0]       w_tx_wdata;
  logic [TX_AW-1:0] w_tx_count;

  assign rx_ready  = !w_rx_full;
  assign w_rx_push = rx_valid && !w_rx_full;
  assign w_rx_pop  = !cpu_wr && (w_io_reg == IO_REG_DATA);
  // A byte that arrives in the same cycle as a read of an empty FIFO is
  // returned directly.
  assign w_rx_byte = (!w_rx_empty || w_rx_push) ? w_rx_rdata : 8'h00;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_rx_push),
    .i_wdata (rx_data),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_unused_rx_count)
  );

  // Only the stop write can put a 0x00 byte into the output stream.
  assign w_tx_push  = cpu_wr && (((w_io_reg == IO_REG_DATA) && (cpu_dout != 8'h00)) ||
                                 (w_io_reg == IO_REG_CTRL));
  assign w_tx_wdata = (w_io_reg == IO_REG_CTRL) ? 8'h00 : cpu_dout;
  assign tx_valid   = !w_tx_empty;
  assign w_tx_pop   = tx_valid && tx_ready;
  assign io_buffer_full = (w_tx_count >= TX_AW'(TX_DEPTH - 2));

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_tx_push),
    .i_wdata (w_tx_wdata),
    .i_pop   (w_tx_pop),
    .o_rdata (tx_data),
    .o_full  (w_unused_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  // ---------------- cycle counter ----------------
  logic [7:0] w_cnt_byte;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] w_cycle_next;
  logic [31:0] r_snapshot;

  assign w_cycle_next = r_cycle_cnt + 32'd1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cycle_cnt <= 32'd0;
      r_snapshot  <= 32'd0;
    end else begin
      r_cycle_cnt <= w_cycle_next;
      if (!cpu_wr && (w_io_reg == IO_REG_CTRL)) r_snapshot <= r_cycle_cnt;
    end
  end

  // Byte 0 comes from the live counter. The upper bytes come from the
  // snapshot, so that a multi-byte read sees one consistent value.
  always_comb begin
    w_cnt_byte = 8'h00;
    case (w_io_reg)
      IO_REG_CTRL:  w_cnt_byte = r_cycle_cnt[7:0];
      IO_REG_SNAP1: w_cnt_byte = r_snapshot[15:8];
      IO_REG_SNAP2: w_cnt_byte = r_snapshot[23:16];
      IO_REG_SNAP3: w_cnt_byte = r_snapshot[31:24];
      default:      w_cnt_byte = 8'h00;
    endcase
  end
`else
  assign w_cnt_byte = 8'h00;
`endif

  // ---------------- IO read path and output register ----------------
  logic [7:0] w_io_rdata;
  logic [7:0] r_io_q;
  logic       r_rd_is_io;
  logic       r_program_stop;

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_io_reg)
      IO_REG_DATA:                             w_io_rdata = w_rx_byte;
      IO_REG_CTRL, IO_REG_SNAP1,
      IO_REG_SNAP2, IO_REG_SNAP3:              w_io_rdata = w_cnt_byte;
      default:                                 w_io_rdata = 8'h00;
    endcase
  end

  // Write cycles leave both result registers alone, so cpu_din holds.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_io_q     <= 8'h00;
      r_rd_is_io <= 1'b0;
    end else if (!cpu_wr) begin
      r_rd_is_io <= w_is_io;
      if (w_is_io) r_io_q <= w_io_rdata;
    end
  end

  assign cpu_din = r_rd_is_io ? r_io_q : r_ram_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                    r_program_stop <= 1'b0;
    else if (cpu_wr && (w_io_reg == IO_REG_CTRL))  r_program_stop <= 1'b1;
  end

  assign program_stop = r_program_stop;

endmodule

// File: tb/tb_mem_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_io_responder
// Purpose : directed plus randomized self-checking bench for mem_io_responder.
//           Inputs change on the falling edge and outputs are sampled there.
//           The random phase compares the DUT against queue/array models of
//           the FIFOs and the RAM.
// ---------------------------------------------------------------------------
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_stop;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IDLE_A = 32'h3000C;
  localparam logic [31:0] DATA_A = 32'h30000;
  localparam logic [31:0] STOP_A = 32'h30004;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .program_stop   (program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    cpu_wr   = wr;
    cpu_a    = a;
    cpu_dout = d;
  endtask

  // reference model state
  logic [7:0]  m_ram [64];
  bit          m_vld [64];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_din;
  bit          din_known;
  logic [7:0]  cnt_exp [6];
  logic [31:0] cnt_adr [6];

  initial begin
    logic [7:0]  data;
    logic [31:0] addr;
    logic [7:0]  popped;
    int          op;
    bit          tx_pop, tx_push, rx_push;

    rst_in = 1'b1;
    drive(1'b0, IDLE_A, 8'h00);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    tick();
    tick();
    check("rst_cpu_din", cpu_din, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_io_full", io_buffer_full, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_stop", program_stop, 0);
    rst_in = 1'b0;

    // RAM write then read of the same address
    drive(1'b1, 32'h10, 8'hA5); tick();
    drive(1'b0, 32'h10, 8'h00); tick();
    check("ram_wr_rd", cpu_din, 8'hA5);
    drive(1'b1, IDLE_A, 8'h99); tick();
    check("din_hold_on_wr", cpu_din, 8'hA5);
    check("io_other_wr_ignored", tx_valid, 0);
    drive(1'b0, IDLE_A, 8'h00); tick();
    check("io_other_rd", cpu_din, 0);
    drive(1'b0, 32'h20010, 8'h00); tick();
    check("ram_alias_bit17_clear", cpu_din, 8'hA5);
    drive(1'b1, 32'hFFF00020, 8'h3C); tick();
    drive(1'b0, 32'h00020, 8'h00); tick();
    check("ram_upper_bits_ignored", cpu_din, 8'h3C);

    // zero data byte on the data port is not emitted
    tx_ready = 1'b1;
    drive(1'b1, DATA_A, 8'h41); tick();
    check("tx_first_valid", tx_valid, 1);
    check("tx_first_data", tx_data, 8'h41);
    drive(1'b1, DATA_A, 8'h00); tick();
    check("tx_zero_ignored", tx_valid, 0);
    drive(1'b1, DATA_A, 8'h42); tick();
    check("tx_second_valid", tx_valid, 1);
    check("tx_second_data", tx_data, 8'h42);
    drive(1'b0, IDLE_A, 8'h00); tick();
    check("tx_drained", tx_valid, 0);

    // output FIFO fill: flag at 14, 15 stored, 16th dropped
    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, DATA_A, 8'(8'h10 + i)); tick();
      check($sformatf("tx_full_flag_%0d", i), io_buffer_full, (i >= 14));
    end
    drive(1'b0, IDLE_A, 8'h00);
    tx_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      check("tx_drain_valid", tx_valid, 1);
      check($sformatf("tx_drain_data_%0d", k), tx_data, 8'(8'h11 + k));
      tick();
    end
    check("tx_drain_done", tx_valid, 0);
    tx_ready = 1'b0;

    // input FIFO single byte then empty
    rx_valid = 1'b1; rx_data = 8'h5A;
    check("rx_ready_empty", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    drive(1'b0, DATA_A, 8'h00); tick();
    check("rx_pop_5a", cpu_din, 8'h5A);
    drive(1'b0, DATA_A, 8'h00); tick();
    check("rx_pop_empty", cpu_din, 8'h00);

    // input FIFO fill to capacity, then drain in order
    drive(1'b0, IDLE_A, 8'h00);
    for (int i = 0; i < 15; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h60 + i);
      tick();
    end
    check("rx_full_not_ready", rx_ready, 0);
    rx_data = 8'hEE; tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, DATA_A, 8'h00); tick();
      check($sformatf("rx_drain_%0d", i), cpu_din, 8'(8'h60 + i));
    end
    drive(1'b0, DATA_A, 8'h00); tick();
    check("rx_drain_empty", cpu_din, 8'h00);
    drive(1'b0, IDLE_A, 8'h00);

    // cycle counter and snapshot across the 32-bit wrap
    cnt_adr = '{STOP_A, STOP_A + 32'd1, STOP_A + 32'd2, STOP_A + 32'd3, STOP_A, STOP_A + 32'd1};
`ifdef CYCLE_COUNTER_EN
    force dut.w_cycle_next = 32'hFFFFFFFE;
    tick();
    release dut.w_cycle_next;
    // counter is FFFFFFFE at the first read, then FFFFFFFF, 0, 1, 2
    cnt_exp = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00};
`else
    tick();
    cnt_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, cnt_adr[i], 8'h00); tick();
      check($sformatf("cnt_rd_%0d", i), cpu_din, cnt_exp[i]);
    end
    drive(1'b0, IDLE_A, 8'h00);

    // stop write, later writes still serviced, reset mid-stream
    check("stop_before", program_stop, 0);
    drive(1'b1, STOP_A, 8'h77); tick();
    check("stop_set", program_stop, 1);
    check("stop_tx_valid", tx_valid, 1);
    check("stop_tx_zero", tx_data, 8'h00);
    drive(1'b1, DATA_A, 8'h33); tick();
    check("stop_sticky", program_stop, 1);
    drive(1'b0, IDLE_A, 8'h00);
    tx_ready = 1'b1;
    check("stop_head_zero", tx_data, 8'h00);
    tick();
    check("after_stop_valid", tx_valid, 1);
    check("after_stop_data", tx_data, 8'h33);
    tx_ready = 1'b0;
    rst_in = 1'b1;
    #1;
    check("midrst_stop", program_stop, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_cpu_din", cpu_din, 0);
    tick();
    rst_in = 1'b0;
    check("midrst_io_full", io_buffer_full, 0);
    check("midrst_rx_ready", rx_ready, 1);

    // RAM survives reset
    drive(1'b0, 32'h10, 8'h00); tick();
    check("ram_kept_over_rst", cpu_din, 8'hA5);

    // randomized phase against the models
    m_ram[16] = 8'hA5; m_vld[16] = 1'b1;
    m_ram[32] = 8'h3C; m_vld[32] = 1'b1;
    exp_din = 8'hA5; din_known = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd_tx_valid", tx_valid, (tx_q.size() != 0));
      if (tx_q.size() != 0) check("rnd_tx_data", tx_data, tx_q[0]);
      check("rnd_io_full", io_buffer_full, (tx_q.size() >= 14));
      check("rnd_rx_ready", rx_ready, (rx_q.size() < 15));
      check("rnd_stop", program_stop, 0);
      if (din_known) check("rnd_cpu_din", cpu_din, exp_din);

      tx_ready = (cyc < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      rx_valid = (cyc < 300) ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0);
      rx_data  = 8'($urandom);
      op       = int'($urandom_range(5));
      addr     = 32'($urandom_range(63));
      data     = 8'($urandom);
      tx_pop   = tx_ready && (tx_q.size() != 0);
      rx_push  = rx_valid && (rx_q.size() < 15);
      tx_push  = 1'b0;

      case (op)
        0: begin
          drive(1'b1, addr, data);
          m_ram[addr[5:0]] = data;
          m_vld[addr[5:0]] = 1'b1;
        end
        1: begin
          drive(1'b0, addr, 8'h00);
          exp_din   = m_ram[addr[5:0]];
          din_known = m_vld[addr[5:0]];
        end
        2: begin
          if ($urandom_range(3) == 0) data = 8'h00;
          drive(1'b1, DATA_A, data);
          tx_push = (data != 8'h00);
        end
        3: begin
          drive(1'b0, DATA_A, 8'h00);
          if (rx_q.size() != 0) begin
            exp_din = rx_q.pop_front();
          end else if (rx_push) begin
            exp_din = rx_data;
            rx_push = 1'b0;
          end else begin
            exp_din = 8'h00;
          end
          din_known = 1'b1;
        end
        4: begin
          drive(1'b0, 32'h30008, 8'h00);
          exp_din   = 8'h00;
          din_known = 1'b1;
        end
        default: begin
          drive(1'b1, IDLE_A, data);
        end
      endcase

      if (tx_pop) popped = tx_q.pop_front();
      if (tx_push && (tx_q.size() < 15)) tx_q.push_back(data);
      if (rx_push) rx_q.push_back(rx_data);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
